// File: rtl/calc_key_sequencer_if.sv
// Keypad-to-ALU sequencer bus: key class flags, ALU request/completion and display outputs.
// master drives keys and ALU completion; slave is the sequencer.
interface calc_key_sequencer_if;
  logic        btn_pressed;
  logic        is_num;
  logic        is_op;
  logic        is_eq;
  logic        clear;
  logic [3:0]  num_val;
  logic [1:0]  op_val;
  logic        alu_done;
  logic        alu_err;
  logic [15:0] alu_result;
  logic [13:0] operand_a;
  logic [13:0] operand_b;
  logic [1:0]  op_sel;
  logic        alu_start;
  logic [15:0] display_val;
  logic [2:0]  state;
  logic        busy;

  modport master (
    output btn_pressed, is_num, is_op, is_eq, clear, num_val, op_val,
    output alu_done, alu_err, alu_result,
    input  operand_a, operand_b, op_sel, alu_start, display_val, state, busy
  );

  modport slave (
    input  btn_pressed, is_num, is_op, is_eq, clear, num_val, op_val,
    input  alu_done, alu_err, alu_result,
    output operand_a, operand_b, op_sel, alu_start, display_val, state, busy
  );
endinterface

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: builds operands from key events, launches the ALU, shows result/error.
// Outputs update one clock after the key/ALU event; no backpressure, events in S_CALC other than clear are dropped.
module calc_key_sequencer #(
  parameter int MAX_DIGITS = 4
) (
  input logic             clk,
  input logic             reset,
  calc_key_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_CALC = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      state_q;
  logic [13:0] operand_a_q;
  logic [13:0] operand_b_q;
  logic [1:0]  op_sel_q;
  logic [2:0]  digit_cnt;
  logic [15:0] result_q;
  logic [15:0] display_q;
  logic        alu_start_q;
  logic        btn_prev;

  logic        key_evt;
  logic        ev_clear;
  logic        ev_eq;
  logic        ev_op;
  logic        ev_num;
  logic        can_append;
  logic [13:0] num14;
  logic [13:0] a_append;
  logic [13:0] b_append;

  // One event per key press; flags decoded with clear > eq > op > num priority.
  assign key_evt    = bus.btn_pressed & ~btn_prev;
  assign ev_clear   = key_evt & bus.clear;
  assign ev_eq      = key_evt & ~bus.clear & bus.is_eq;
  assign ev_op      = key_evt & ~bus.clear & ~bus.is_eq & bus.is_op;
  assign ev_num     = key_evt & ~bus.clear & ~bus.is_eq & ~bus.is_op & bus.is_num
                      & (bus.num_val <= 4'd9);

  assign can_append = digit_cnt < 3'(MAX_DIGITS);
  assign num14      = {10'd0, bus.num_val};
  assign a_append   = operand_a_q * 14'd10 + num14;
  assign b_append   = operand_b_q * 14'd10 + num14;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_A;
      operand_a_q <= '0;
      operand_b_q <= '0;
      op_sel_q    <= '0;
      digit_cnt   <= '0;
      result_q    <= '0;
      display_q   <= '0;
      alu_start_q <= 1'b0;
      btn_prev    <= 1'b0;
    end else begin
      btn_prev    <= bus.btn_pressed;
      alu_start_q <= 1'b0;
      if (ev_clear) begin
        // Abort from any state; a late alu_done then lands outside S_CALC and is ignored.
        state_q     <= S_A;
        operand_a_q <= '0;
        operand_b_q <= '0;
        op_sel_q    <= '0;
        digit_cnt   <= '0;
        result_q    <= '0;
        display_q   <= '0;
      end else begin
        case (state_q)
          S_A: begin
            if (ev_num && can_append) begin
              operand_a_q <= a_append;
              digit_cnt   <= digit_cnt + 3'd1;
              display_q   <= {2'b00, a_append};
            end else if (ev_op) begin
              op_sel_q <= bus.op_val;
              state_q  <= S_OP;
            end
          end
          S_OP: begin
            if (ev_num) begin
              operand_b_q <= num14;
              digit_cnt   <= 3'd1;
              display_q   <= {2'b00, num14};
              state_q     <= S_B;
            end else if (ev_op) begin
              op_sel_q <= bus.op_val;
            end
          end
          S_B: begin
            if (ev_num && can_append) begin
              operand_b_q <= b_append;
              digit_cnt   <= digit_cnt + 3'd1;
              display_q   <= {2'b00, b_append};
            end else if (ev_eq) begin
              state_q     <= S_CALC;
              alu_start_q <= 1'b1;
            end
          end
          S_CALC: begin
            if (bus.alu_done) begin
              if (bus.alu_err) begin
                state_q   <= S_ERR;
                display_q <= 16'hFFFF;
              end else begin
                result_q  <= bus.alu_result;
                display_q <= bus.alu_result;
                state_q   <= S_RES;
              end
            end
          end
          S_RES: begin
            if (ev_num) begin
              operand_a_q <= num14;
              operand_b_q <= '0;
              digit_cnt   <= 3'd1;
              display_q   <= {2'b00, num14};
              state_q     <= S_A;
            end else if (ev_op) begin
              // Chaining is only possible when the result fits back into an operand.
              if (result_q <= 16'd9999) begin
                operand_a_q <= result_q[13:0];
                operand_b_q <= '0;
                op_sel_q    <= bus.op_val;
                display_q   <= {2'b00, result_q[13:0]};
                state_q     <= S_OP;
              end else begin
                display_q <= 16'hFFFF;
                state_q   <= S_ERR;
              end
            end
          end
          S_ERR: begin
          end
          default: begin
            state_q <= S_A;
          end
        endcase
      end
    end
  end

  assign bus.operand_a   = operand_a_q;
  assign bus.operand_b   = operand_b_q;
  assign bus.op_sel      = op_sel_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.display_val = display_q;
  assign bus.state       = state_q;
  assign bus.busy        = (state_q == S_CALC);

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Randomized and directed bench for calc_key_sequencer with a scoreboard fed by a calculator reference model.
`timescale 1ns/1ps
module tb_calc_key_sequencer;

  localparam int MAXD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  calc_key_sequencer_if bus();

  calc_key_sequencer #(.MAX_DIGITS(MAXD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {int st; int a; int b; int op; int disp;} snap_t;
  typedef struct {int a; int b; int op;} req_t;

  snap_t snap_q[$];
  req_t  alu_q[$];
  int    checks = 0;
  int    errors = 0;

  // Calculator model: state numbers follow the documented encoding.
  int m_state, m_a, m_b, m_op, m_cnt, m_res, m_disp;

  int resp_lat       = 3;
  int resp_force_val = -1;
  bit resp_force_err = 1'b0;
  bit resp_busy      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_cnt = 0; m_res = 0; m_disp = 0;
  endfunction

  function automatic int disp_now();
    case (m_state)
      0, 1:    return m_a;
      2:       return m_b;
      3:       return m_disp;
      4:       return m_res;
      default: return 'hFFFF;
    endcase
  endfunction

  function automatic void m_push();
    snap_t s;
    m_disp = disp_now();
    s = '{m_state, m_a, m_b, m_op, m_disp};
    snap_q.push_back(s);
  endfunction

  function automatic void model_key(bit c, bit e, bit o, bit n, int nv, int ov);
    req_t r;
    if (c) begin
      m_reset();
    end else if (e) begin
      if (m_state == 2) begin
        m_state = 3;
        r = '{m_a, m_b, m_op};
        alu_q.push_back(r);
      end
    end else if (o) begin
      case (m_state)
        0: begin m_op = ov; m_state = 1; end
        1: m_op = ov;
        4: begin
          if (m_res <= 9999) begin
            m_a = m_res; m_b = 0; m_op = ov; m_state = 1;
          end else begin
            m_state = 5;
          end
        end
        default: ;
      endcase
    end else if (n && nv <= 9) begin
      case (m_state)
        0: if (m_cnt < MAXD) begin m_a = m_a * 10 + nv; m_cnt++; end
        1: begin m_b = nv; m_cnt = 1; m_state = 2; end
        2: if (m_cnt < MAXD) begin m_b = m_b * 10 + nv; m_cnt++; end
        4: begin m_a = nv; m_b = 0; m_cnt = 1; m_state = 0; end
        default: ;
      endcase
    end
    m_push();
  endfunction

  function automatic void model_done(bit err, int res);
    if (m_state == 3) begin
      if (err) m_state = 5;
      else begin m_res = res; m_state = 4; end
    end
    m_push();
  endfunction

  task automatic press(input bit c, input bit e, input bit o, input bit n,
                       input int nv, input int ov, input int hold);
    @(negedge clk);
    bus.clear = c; bus.is_eq = e; bus.is_op = o; bus.is_num = n;
    bus.num_val = 4'(nv); bus.op_val = 2'(ov); bus.btn_pressed = 1'b1;
    model_key(c, e, o, n, nv, ov);
    repeat (hold) @(negedge clk);
    bus.btn_pressed = 1'b0;
    bus.clear = 1'b0; bus.is_eq = 1'b0; bus.is_op = 1'b0; bus.is_num = 1'b0;
    @(negedge clk);
  endtask

  task automatic key_num(input int v);  press(0, 0, 0, 1, v, 0, 1); endtask
  task automatic key_op(input int o);   press(0, 0, 1, 0, 0, o, 1); endtask
  task automatic key_eq();              press(0, 1, 0, 0, 0, 0, 1); endtask
  task automatic key_clr();             press(1, 0, 0, 0, 0, 0, 1); endtask

  task automatic wait_idle();
    int n = 0;
    while (resp_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("alu_idle_timeout", {31'd0, resp_busy}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".state"},     bus.state, 0);
    chk({tag, ".operand_a"}, bus.operand_a, 0);
    chk({tag, ".operand_b"}, bus.operand_b, 0);
    chk({tag, ".op_sel"},    bus.op_sel, 0);
    chk({tag, ".alu_start"}, bus.alu_start, 0);
    chk({tag, ".busy"},      bus.busy, 0);
    chk({tag, ".display"},   bus.display_val, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0;
  endtask

  // ALU stand-in: computes the arithmetic from the model's operands unless forced.
  int r_res;
  bit r_err;
  initial begin
    bus.alu_done = 1'b0; bus.alu_err = 1'b0; bus.alu_result = '0;
    forever begin
      @(negedge clk);
      if (bus.alu_start === 1'b1 && !reset) begin
        resp_busy = 1'b1;
        r_err = 1'b0;
        case (m_op)
          0: r_res = (m_a + m_b) & 'hFFFF;
          1: r_res = (m_a - m_b) & 'hFFFF;
          2: r_res = (m_a * m_b) & 'hFFFF;
          default: begin
            if (m_b == 0) begin r_err = 1'b1; r_res = 0; end
            else r_res = m_a / m_b;
          end
        endcase
        if (resp_force_err) r_err = 1'b1;
        if (resp_force_val >= 0) r_res = resp_force_val;
        resp_force_err = 1'b0;
        resp_force_val = -1;
        repeat (resp_lat) @(negedge clk);
        bus.alu_done = 1'b1; bus.alu_err = r_err; bus.alu_result = 16'(r_res);
        model_done(r_err, r_res);
        @(negedge clk);
        bus.alu_done = 1'b0; bus.alu_err = 1'b0;
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: an output snapshot is due the cycle after each key edge or alu_done.
  bit    mon_prev, mon_ev, mon_dn, mon_rst;
  snap_t ms;
  req_t  mr;
  initial begin
    mon_prev = 1'b0;
    forever begin
      @(posedge clk);
      mon_rst = reset;
      if (reset) begin
        mon_prev = 1'b0; mon_ev = 1'b0; mon_dn = 1'b0;
      end else begin
        mon_ev   = bus.btn_pressed && !mon_prev;
        mon_prev = bus.btn_pressed;
        mon_dn   = bus.alu_done;
      end
      @(negedge clk);
      if (!mon_rst) begin
        if (mon_ev || mon_dn) begin
          if (snap_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL snap_underflow: got event, expected none queued");
          end else begin
            ms = snap_q.pop_front();
            chk("snap.state",     bus.state, ms.st);
            chk("snap.operand_a", bus.operand_a, ms.a);
            chk("snap.operand_b", bus.operand_b, ms.b);
            chk("snap.op_sel",    bus.op_sel, ms.op);
            chk("snap.display",   bus.display_val, ms.disp);
            chk("snap.busy",      bus.busy, (ms.st == 3) ? 1 : 0);
          end
        end
        if (bus.alu_start === 1'b1) begin
          if (alu_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL alu_start_unexpected: got pulse, expected none");
          end else begin
            mr = alu_q.pop_front();
            chk("start.operand_a", bus.operand_a, mr.a);
            chk("start.operand_b", bus.operand_b, mr.b);
            chk("start.op_sel",    bus.op_sel, mr.op);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, e, o, n, nv;
    reset = 1'b1;
    bus.btn_pressed = 1'b0; bus.is_num = 1'b0; bus.is_op = 1'b0; bus.is_eq = 1'b0;
    bus.clear = 1'b0; bus.num_val = '0; bus.op_val = '0;
    m_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // 12 + 3 = 15 with a 4-cycle ALU, then chain 15 - 5
    resp_lat = 4;
    key_num(1); key_num(2); key_op(0); key_num(3); key_eq();
    wait_idle();
    key_op(1); key_num(5); key_eq();
    wait_idle();
    // Oversized result cannot be chained
    key_op(0); key_num(1); resp_force_val = 20000; key_eq();
    wait_idle();
    key_op(2);
    key_clr();

    // Held key gives one event
    press(0, 0, 0, 1, 7, 0, 10);
    key_clr();

    // Digit limit and out-of-range digit
    key_num(1); key_num(2); key_num(3); key_num(4); key_num(5); key_num(12);
    key_clr();

    // Divide by zero, error state is sticky until clear
    key_num(9); key_op(3); key_num(0); key_eq();
    wait_idle();
    key_num(4); key_op(0); key_eq();
    key_clr();

    // Clear during calculation, late alu_done ignored
    key_num(1); key_op(0); key_num(2); resp_lat = 8; key_eq();
    key_clr();
    wait_idle();

    // Reset during calculation
    key_num(5); key_op(0); key_num(5); key_eq();
    do_reset();
    wait_idle();

    // Key with no class flag, and multi-flag priority
    press(0, 0, 0, 0, 3, 0, 1);
    press(0, 0, 1, 1, 6, 2, 1);
    key_clr();

    repeat (400) begin
      c  = ($urandom_range(0, 29) == 0) ? 1 : 0;
      e  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      o  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      n  = $urandom_range(0, 1);
      nv = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      resp_lat = $urandom_range(1, 5);
      press(c[0], e[0], o[0], n[0], nv, $urandom_range(0, 3), $urandom_range(1, 3));
      if (m_state == 3) wait_idle();
    end

    repeat (5) @(negedge clk);
    chk("snap_queue_left", snap_q.size(), 0);
    chk("alu_queue_left",  alu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_key_sequencer.md
CALC_KEY_SEQUENCER -- requirements
Module: calc_key_sequencer

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4: maximum decimal digits per operand (operand width fixed at 14 bits; MAX_DIGITS <= 4).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port btn_pressed  input  1  registered key-down level from the keypad decoder stage.
REQ-005 SHALL have port is_num / is_op / is_eq / clear  input  1 each  registered key class flags.
REQ-006 SHALL have port num_val  input  4  digit value; port op_val  input  2  operator code (00 add, 01 sub, 10 mul, 11 div).
REQ-007 SHALL have port alu_done  input  1  ALU completion pulse; alu_err  input  1  ALU error, valid with alu_done; alu_result  input  16  ALU result, valid with alu_done.
REQ-008 SHALL have port operand_a, operand_b  output  14 each  operands to ALU; op_sel  output  2  operator to ALU.
REQ-009 SHALL have port alu_start  output  1  single-cycle ALU start pulse.
REQ-010 SHALL have port display_val  output  16  value to display; state  output  3  current FSM state; busy  output  1  high in S_CALC.

Function
REQ-011 SHALL detect a key event only on the rising edge of btn_pressed (btn_pressed=1 and previous-cycle btn_pressed=0); a held key SHALL produce exactly one event.
REQ-012 SHALL decode a key event with priority clear > is_eq > is_op > is_num; an event with no flag set SHALL be ignored.
REQ-013 SHALL ignore a num event with num_val > 9 (no state or operand change).
REQ-014 SHALL encode states S_A=0, S_OP=1, S_B=2, S_CALC=3, S_RES=4, S_ERR=5; all outputs SHALL update on the clock edge following the event cycle.
REQ-015 SHALL, on a clear event in any state (including S_CALC), zero operand_a, operand_b, op_sel, digit count and result register and go to S_A; an alu_done arriving after abort SHALL be ignored.
REQ-016 S_A: num -> operand_a = operand_a*10 + num_val if digit count < MAX_DIGITS, else ignored; op -> op_sel = op_val, go S_OP; eq ignored.
REQ-017 S_OP: num -> operand_b = num_val, digit count = 1, go S_B; op -> op_sel replaced; eq ignored.
REQ-018 S_B: num -> append to operand_b with the S_A digit-limit rule; op ignored; eq -> go S_CALC.
REQ-019 SHALL assert alu_start for exactly one cycle, in the first cycle of S_CALC; operand_a, operand_b, op_sel SHALL be stable from that cycle until alu_done.
REQ-020 S_CALC: all non-clear events ignored; alu_done with alu_err=1 -> S_ERR; alu_done with alu_err=0 -> latch alu_result, go S_RES.
REQ-021 S_RES: num -> operand_a = num_val, operand_b = 0, digit count = 1, go S_A; op -> if result <= 9999 then operand_a = result[13:0], operand_b = 0, op_sel = op_val, go S_OP, else go S_ERR; eq ignored.
REQ-022 S_ERR: only clear leaves; all other events ignored.
REQ-023 display_val SHALL be {2'b00, operand_a} in S_A and S_OP, {2'b00, operand_b} in S_B, the previously displayed value in S_CALC, the latched result in S_RES, 16'hFFFF in S_ERR.
REQ-024 busy SHALL equal (state == S_CALC).

Reset
REQ-025 While reset=1: state=S_A, operand_a=0, operand_b=0, op_sel=00, alu_start=0, busy=0, display_val=0, digit count=0, result register=0, previous btn_pressed=0.
REQ-026 Reset asserted mid-S_CALC SHALL abort without an alu_start or other output glitch; post-reset alu_done SHALL be ignored.

Verification
REQ-027 Keys 1,2,+,3,= with ALU returning 15 after 4 cycles -> operand_a=12, op_sel=00, operand_b=3, one alu_start pulse, display_val=15, state=4.
REQ-028 btn_pressed held high 10 cycles with is_num, num_val=7 in S_A -> operand_a=7 (single event).
REQ-029 Digits 1,2,3,4,5 -> operand_a=1234; 5th digit ignored; num_val=12 ignored.
REQ-030 Keys 9,/,0,= with alu_err=1 on alu_done -> state=5, display_val=16'hFFFF; then digit ignored; clear -> state=0, display_val=0.
REQ-031 Result 15 in S_RES, then -,5,= -> operand_a=15, op_sel=01, operand_b=5; result 20000 then op -> state=5.
REQ-032 Clear in S_CALC, then alu_done -> state=0, result not latched, display_val=0.
